// File: rtl/frame_cfg_pkg.sv
// -----------------------------------------------------------------------------
// frame_cfg_pkg
// Shared definitions for the frame row writer: FSM state encoding, header sync
// constant, header field bit positions and small field-extraction helpers.
// -----------------------------------------------------------------------------
package frame_cfg_pkg;

   // Writer FSM states
   typedef enum logic [1:0] {
      ST_HDR    = 2'd0,
      ST_DATA   = 2'd1,
      ST_STROBE = 2'd2
   } state_t;

   // Header layout (always occupies the low 32 bits of a frame word)
   localparam int HDR_BITS       = 32;
   localparam int SYNC_MSB       = 31;
   localparam int SYNC_LSB       = 24;
   localparam int CNT_MSB        = 12;
   localparam int CNT_LSB        = 8;
   localparam int START_MSB      = 4;
   localparam int START_LSB      = 0;
   localparam int FIELD_WIDTH    = 5;
   localparam int ROW_CALC_WIDTH = 6;   // holds S+N-1 without overflow

   localparam logic [7:0] SYNC_BYTE = 8'hFA;

   function automatic logic [7:0] hdr_sync(input logic [HDR_BITS-1:0] hdr);
      return hdr[SYNC_MSB:SYNC_LSB];
   endfunction

   function automatic logic [FIELD_WIDTH-1:0] hdr_count(input logic [HDR_BITS-1:0] hdr);
      return hdr[CNT_MSB:CNT_LSB];
   endfunction

   function automatic logic [FIELD_WIDTH-1:0] hdr_start(input logic [HDR_BITS-1:0] hdr);
      return hdr[START_MSB:START_LSB];
   endfunction

endpackage

// File: rtl/frame_hdr_check.sv
// -----------------------------------------------------------------------------
// frame_hdr_check
// Purely combinational header validation.
// Ports:
//   hdr      in  32  candidate header word
//   max_rows in  6   highest legal row number
//   ok       out 1   header is acceptable
// A header is rejected on a bad sync byte, a zero row count, a zero start row,
// or when the last addressed row (S+N-1) lies beyond max_rows.
// -----------------------------------------------------------------------------
module frame_hdr_check
   import frame_cfg_pkg::*;
(
   input  logic [HDR_BITS-1:0]       hdr,
   input  logic [ROW_CALC_WIDTH-1:0] max_rows,
   output logic                      ok
);

   logic [FIELD_WIDTH-1:0]    count_s;
   logic [FIELD_WIDTH-1:0]    start_s;
   logic [ROW_CALC_WIDTH-1:0] last_row_s;

   assign count_s = hdr_count(hdr);
   assign start_s = hdr_start(hdr);

   // Start and count are both >= 1 whenever this result matters, so no underflow
   assign last_row_s = {1'b0, start_s} + {1'b0, count_s} - 6'd1;

   // Combine all acceptance conditions into one flag
   always_comb begin
      ok = 1'b0;
      if ((hdr_sync(hdr) == SYNC_BYTE) && (count_s != 5'd0) &&
          (start_s != 5'd0) && (last_row_s <= max_rows)) begin
         ok = 1'b1;
      end else begin
         ok = 1'b0;
      end
   end

endmodule

// File: rtl/frame_row_writer.sv
// -----------------------------------------------------------------------------
// frame_row_writer
// Receives a header followed by N data words on a valid/ready stream and
// broadcasts each data word with the row number it targets, then pulses a
// frame strobe once the last row has been written.
// Ports:
//   CLK          in   1                clock, rising edge
//   resetn       in   1                asynchronous active-low reset
//   s_data       in   FrameBitsPerRow  header/data word
//   s_valid      in   1                s_data valid
//   s_ready      out  1                registered ready
//   abort        in   1                synchronous frame cancel
//   FrameData_O  out  FrameBitsPerRow  row data (holds last value)
//   RowSelect    out  RowSelectWidth   target row, 0 = none
//   FrameStrobe  out  1                frame-complete pulse
//   hdr_err      out  1                rejected-header pulse
// -----------------------------------------------------------------------------
module frame_row_writer
   import frame_cfg_pkg::*;
#(
   parameter int FrameBitsPerRow = 32,
   parameter int RowSelectWidth  = 5,
   parameter int MaxRows         = 14
)
(
   input  logic                       CLK,
   input  logic                       resetn,
   input  logic [FrameBitsPerRow-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       abort,
   output logic [FrameBitsPerRow-1:0] FrameData_O,
   output logic [RowSelectWidth-1:0]  RowSelect,
   output logic                       FrameStrobe,
   output logic                       hdr_err
);

   state_t                     state_q, state_d;
   logic [RowSelectWidth-1:0]  row_q, row_d;
   logic [FIELD_WIDTH-1:0]     rem_q, rem_d;
   logic                       s_ready_q, s_ready_d;
   logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
   logic [RowSelectWidth-1:0]  row_select_q, row_select_d;
   logic                       frame_strobe_q, frame_strobe_d;
   logic                       hdr_err_q, hdr_err_d;

   logic                       hdr_ok_s;
   logic                       accept_s;
   logic                       last_word_s;

   frame_hdr_check u_hdr_check (
      .hdr      (s_data[HDR_BITS-1:0]),
      .max_rows (ROW_CALC_WIDTH'(MaxRows)),
      .ok       (hdr_ok_s)
   );

   // abort wins over s_valid; s_ready is already low in STROBE so abort there is moot
   assign accept_s    = s_valid && s_ready_q && !abort;
   assign last_word_s = (rem_q == 5'd1);

   // State register
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_HDR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR: begin
            if (accept_s && hdr_ok_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_DATA: begin
            if (abort) begin
               state_d = ST_HDR;
            end else if (accept_s && last_word_s) begin
               state_d = ST_STROBE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STROBE: begin
            state_d = ST_HDR;
         end
         default: begin
            state_d = ST_HDR;
         end
      endcase
   end

   // Output and datapath next values
   always_comb begin
      row_d          = row_q;
      rem_d          = rem_q;
      frame_data_d   = frame_data_q;
      row_select_d   = '0;
      hdr_err_d      = 1'b0;
      // Strobe follows the STROBE cycle, i.e. the cycle after the last row pulse
      frame_strobe_d = (state_q == ST_STROBE);
      // Ready drops at the same edge that takes the last data word
      s_ready_d      = (state_d != ST_STROBE);
      case (state_q)
         ST_HDR: begin
            if (accept_s && hdr_ok_s) begin
               row_d = RowSelectWidth'(hdr_start(s_data[HDR_BITS-1:0]));
               rem_d = hdr_count(s_data[HDR_BITS-1:0]);
            end else if (accept_s) begin
               hdr_err_d = 1'b1;
            end else begin
               hdr_err_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               frame_data_d = s_data;
               row_select_d = row_q;
               row_d        = row_q + RowSelectWidth'(1'b1);
               rem_d        = rem_q - 5'd1;
            end else begin
               row_select_d = '0;
            end
         end
         ST_STROBE: begin
            row_select_d = '0;
         end
         default: begin
            row_select_d = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         row_q          <= '0;
         rem_q          <= '0;
         s_ready_q      <= 1'b0;
         frame_data_q   <= '0;
         row_select_q   <= '0;
         frame_strobe_q <= 1'b0;
         hdr_err_q      <= 1'b0;
      end else begin
         row_q          <= row_d;
         rem_q          <= rem_d;
         s_ready_q      <= s_ready_d;
         frame_data_q   <= frame_data_d;
         row_select_q   <= row_select_d;
         frame_strobe_q <= frame_strobe_d;
         hdr_err_q      <= hdr_err_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign FrameData_O = frame_data_q;
   assign RowSelect   = row_select_q;
   assign FrameStrobe = frame_strobe_q;
   assign hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_frame_row_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_row_writer
// Directed, self-checking bench for frame_row_writer. Inputs change 1 ns after
// a rising edge; outputs are sampled at that same point, so each sample shows
// the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_frame_row_writer;

   logic        CLK;
   logic        resetn;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        abort;
   logic [31:0] FrameData_O;
   logic [4:0]  RowSelect;
   logic        FrameStrobe;
   logic        hdr_err;

   int checks;
   int errors;

   frame_row_writer #(
      .FrameBitsPerRow (32),
      .RowSelectWidth  (5),
      .MaxRows         (14)
   ) dut (
      .CLK         (CLK),
      .resetn      (resetn),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .abort       (abort),
      .FrameData_O (FrameData_O),
      .RowSelect   (RowSelect),
      .FrameStrobe (FrameStrobe),
      .hdr_err     (hdr_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one cycle of stimulus and return 1 ns after the capturing edge
   task automatic cycle(input logic v, input logic [31:0] d, input logic a);
      s_valid = v;
      s_data  = d;
      abort   = a;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      resetn  = 1'b1;
      s_valid = 1'b0;
      s_data  = 32'h0;
      abort   = 1'b0;
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({FrameData_O, RowSelect, FrameStrobe, hdr_err, s_ready} !== 40'h0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h row=%0d strobe=%b err=%b ready=%b, expected all 0",
                  FrameData_O, RowSelect, FrameStrobe, hdr_err, s_ready);
      end
      @(posedge CLK); #1;
      resetn = 1'b1;
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_low: got %b expected 0", s_ready);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_rise: got %b expected 1", s_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] words [3];
      words[0] = 32'hDEAD0001;
      words[1] = 32'hBEEF0002;
      words[2] = 32'hCAFE0003;
      cycle(1'b1, 32'hFA000301, 1'b0);
      checks++;
      if (RowSelect !== 5'd0 || hdr_err !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_hdr: got row=%0d err=%b ready=%b expected 0 0 1", RowSelect, hdr_err, s_ready);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, words[i], 1'b0);
         checks++;
         if (RowSelect !== 5'(i + 1) || FrameData_O !== words[i] || FrameStrobe !== 1'b0 ||
             s_ready !== (i < 2)) begin
            errors++;
            $display("FAIL basic_word%0d: got row=%0d data=%h strobe=%b ready=%b expected row=%0d data=%h strobe=0 ready=%b",
                     i, RowSelect, FrameData_O, FrameStrobe, s_ready, i + 1, words[i], (i < 2));
         end
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b1 || RowSelect !== 5'd0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_strobe: got strobe=%b row=%0d ready=%b expected 1 0 1", FrameStrobe, RowSelect, s_ready);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b0 || RowSelect !== 5'd0 || FrameData_O !== words[2]) begin
         errors++;
         $display("FAIL basic_after: got strobe=%b row=%0d data=%h expected 0 0 %h",
                  FrameStrobe, RowSelect, FrameData_O, words[2]);
      end
   endtask

   task automatic test_boundary();
      // S=12, N=3: last row 14 is legal
      cycle(1'b1, 32'hFA00030C, 1'b0);
      checks++;
      if (hdr_err !== 1'b0) begin
         errors++;
         $display("FAIL bound_ok_hdr: got err=%b expected 0", hdr_err);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h00000100 + 32'(i), 1'b0);
         checks++;
         if (RowSelect !== 5'(12 + i)) begin
            errors++;
            $display("FAIL bound_row%0d: got %0d expected %0d", i, RowSelect, 12 + i);
         end
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b1) begin
         errors++;
         $display("FAIL bound_strobe: got %b expected 1", FrameStrobe);
      end
      // S=13, N=3: last row 15 is out of range
      cycle(1'b1, 32'hFA00030D, 1'b0);
      checks++;
      if (hdr_err !== 1'b1 || RowSelect !== 5'd0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL bound_bad_hdr: got err=%b row=%0d ready=%b expected 1 0 1", hdr_err, RowSelect, s_ready);
      end
      // Still in HDR: an arbitrary word is treated as a (bad) header
      cycle(1'b1, 32'h12345678, 1'b0);
      checks++;
      if (hdr_err !== 1'b1 || RowSelect !== 5'd0) begin
         errors++;
         $display("FAIL bound_still_hdr: got err=%b row=%0d expected 1 0", hdr_err, RowSelect);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (hdr_err !== 1'b0) begin
         errors++;
         $display("FAIL bound_err_pulse: got %b expected 0", hdr_err);
      end
   endtask

   task automatic test_bad_header();
      logic [31:0] vec [4];
      vec[0] = 32'hFB000301;   // wrong sync
      vec[1] = 32'hA5A5A5A5;   // stray word
      vec[2] = 32'hFA000001;   // N = 0
      vec[3] = 32'hFA000300;   // S = 0
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vec[i], 1'b0);
         checks++;
         if (hdr_err !== 1'b1 || RowSelect !== 5'd0 || FrameStrobe !== 1'b0) begin
            errors++;
            $display("FAIL bad_hdr%0d: got err=%b row=%0d strobe=%b expected 1 0 0",
                     i, hdr_err, RowSelect, FrameStrobe);
         end
      end
      // Valid header N=1, S=5
      cycle(1'b1, 32'hFA000105, 1'b0);
      checks++;
      if (hdr_err !== 1'b0 || RowSelect !== 5'd0) begin
         errors++;
         $display("FAIL bad_recover_hdr: got err=%b row=%0d expected 0 0", hdr_err, RowSelect);
      end
      cycle(1'b1, 32'h5555AAAA, 1'b0);
      checks++;
      if (RowSelect !== 5'd5 || FrameData_O !== 32'h5555AAAA || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL bad_recover_word: got row=%0d data=%h ready=%b expected 5 5555aaaa 0",
                  RowSelect, FrameData_O, s_ready);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b1) begin
         errors++;
         $display("FAIL bad_recover_strobe: got %b expected 1", FrameStrobe);
      end
   endtask

   task automatic test_gaps();
      cycle(1'b1, 32'hFA000202, 1'b0);
      cycle(1'b1, 32'h0000AAAA, 1'b0);
      checks++;
      if (RowSelect !== 5'd2 || FrameData_O !== 32'h0000AAAA) begin
         errors++;
         $display("FAIL gap_word0: got row=%0d data=%h expected 2 0000aaaa", RowSelect, FrameData_O);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 32'hFFFFFFFF, 1'b0);
         checks++;
         if (RowSelect !== 5'd0 || FrameData_O !== 32'h0000AAAA || s_ready !== 1'b1 || FrameStrobe !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle%0d: got row=%0d data=%h ready=%b strobe=%b expected 0 0000aaaa 1 0",
                     i, RowSelect, FrameData_O, s_ready, FrameStrobe);
         end
      end
      cycle(1'b1, 32'h0000BBBB, 1'b0);
      checks++;
      if (RowSelect !== 5'd3 || FrameData_O !== 32'h0000BBBB || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL gap_word1: got row=%0d data=%h ready=%b expected 3 0000bbbb 0",
                  RowSelect, FrameData_O, s_ready);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b1) begin
         errors++;
         $display("FAIL gap_strobe: got %b expected 1", FrameStrobe);
      end
   endtask

   task automatic test_abort();
      cycle(1'b1, 32'hFA000401, 1'b0);
      cycle(1'b1, 32'h11110001, 1'b0);
      checks++;
      if (RowSelect !== 5'd1) begin
         errors++;
         $display("FAIL abort_word0: got row=%0d expected 1", RowSelect);
      end
      cycle(1'b1, 32'h22220002, 1'b1);
      checks++;
      if (RowSelect !== 5'd0 || FrameData_O !== 32'h11110001 || FrameStrobe !== 1'b0) begin
         errors++;
         $display("FAIL abort_word1: got row=%0d data=%h strobe=%b expected 0 11110001 0",
                  RowSelect, FrameData_O, FrameStrobe);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b0 || RowSelect !== 5'd0) begin
         errors++;
         $display("FAIL abort_no_strobe: got strobe=%b row=%0d expected 0 0", FrameStrobe, RowSelect);
      end
      // Next header N=1, S=3 accepted
      cycle(1'b1, 32'hFA000103, 1'b0);
      checks++;
      if (hdr_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_next_hdr: got err=%b expected 0", hdr_err);
      end
      cycle(1'b1, 32'h33330003, 1'b0);
      checks++;
      if (RowSelect !== 5'd3 || FrameData_O !== 32'h33330003) begin
         errors++;
         $display("FAIL abort_next_word: got row=%0d data=%h expected 3 33330003", RowSelect, FrameData_O);
      end
      // abort raised during STROBE must not cancel the strobe
      cycle(1'b0, 32'h0, 1'b1);
      checks++;
      if (FrameStrobe !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_strobe: got %b expected 1", FrameStrobe);
      end
      cycle(1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 32'hFA000301, 1'b0);
      cycle(1'b1, 32'h77770001, 1'b0);
      checks++;
      if (RowSelect !== 5'd1 || FrameData_O !== 32'h77770001) begin
         errors++;
         $display("FAIL rstmid_pre: got row=%0d data=%h expected 1 77770001", RowSelect, FrameData_O);
      end
      s_valid = 1'b0;
      resetn  = 1'b0;
      #1;
      checks++;
      if ({FrameData_O, RowSelect, FrameStrobe, hdr_err, s_ready} !== 40'h0) begin
         errors++;
         $display("FAIL rstmid_immediate: got data=%h row=%0d strobe=%b err=%b ready=%b expected all 0",
                  FrameData_O, RowSelect, FrameStrobe, hdr_err, s_ready);
      end
      repeat (2) @(posedge CLK);
      #1;
      resetn = 1'b1;
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (s_ready !== 1'b1 || FrameStrobe !== 1'b0 || RowSelect !== 5'd0) begin
         errors++;
         $display("FAIL rstmid_release: got ready=%b strobe=%b row=%0d expected 1 0 0",
                  s_ready, FrameStrobe, RowSelect);
      end
      cycle(1'b1, 32'hFA000202, 1'b0);
      checks++;
      if (hdr_err !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_hdr: got err=%b expected 0", hdr_err);
      end
      cycle(1'b1, 32'h88880002, 1'b0);
      checks++;
      if (RowSelect !== 5'd2 || FrameData_O !== 32'h88880002) begin
         errors++;
         $display("FAIL rstmid_word0: got row=%0d data=%h expected 2 88880002", RowSelect, FrameData_O);
      end
      cycle(1'b1, 32'h99990003, 1'b0);
      checks++;
      if (RowSelect !== 5'd3 || FrameData_O !== 32'h99990003) begin
         errors++;
         $display("FAIL rstmid_word1: got row=%0d data=%h expected 3 99990003", RowSelect, FrameData_O);
      end
      cycle(1'b0, 32'h0, 1'b0);
      checks++;
      if (FrameStrobe !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_strobe: got %b expected 1", FrameStrobe);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_bad_header();
      test_gaps();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
